// File: rtl/io_port_pkg.sv
// Shared register-map constants and offset helpers for the IO port bank.
package io_port_pkg;

    localparam logic [1:0] OFF_OUT    = 2'd0;
    localparam logic [1:0] OFF_IN     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_ENABLE = 2'd3;
    localparam int         STRIDE     = 4;

    function automatic logic [3:0] reg_offset(input int port, input logic [1:0] off);
        return 4'(STRIDE * port) + {2'b00, off};
    endfunction

    // NMISEL sits directly after the last channel's register group.
    function automatic logic [3:0] nmisel_offset(input int num_ports);
        return 4'(STRIDE * num_ports);
    endfunction

endpackage

// File: rtl/io_port_chan.sv
// One 8-bit port channel: input synchroniser, rise detect, OUT/STATUS/ENABLE
// registers and the per-channel pending flag.
module io_port_chan (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pins_in,
    input  logic       wr_out,
    input  logic       wr_status,
    input  logic       wr_enable,
    input  logic [7:0] wdata,
    output logic [7:0] out_o,
    output logic [7:0] in_o,
    output logic [7:0] status_o,
    output logic [7:0] enable_o,
    output logic       pend_o
);

    logic [7:0] meta_q,   meta_d;
    logic [7:0] sync_q,   sync_d;
    logic [7:0] prev_q,   prev_d;
    logic [7:0] armed_q,  armed_d;
    logic [1:0] fill_q,   fill_d;
    logic [7:0] out_q,    out_d;
    logic [7:0] status_q, status_d;
    logic [7:0] enable_q, enable_d;
    logic [7:0] rise;

    // A bit only becomes armed once the synchroniser has filled and has seen
    // it low, so inputs already high at reset release never count as a rise.
    assign rise = sync_q & ~prev_q & armed_q;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        meta_d   = pins_in;
        sync_d   = meta_q;
        prev_d   = sync_q;
        fill_d   = {fill_q[0], 1'b1};
        armed_d  = armed_q | ({8{fill_q[1]}} & ~sync_q);
        out_d    = out_q;
        enable_d = enable_q;
        status_d = status_q;
        if (wr_out)    out_d    = wdata;
        if (wr_enable) enable_d = wdata;
        if (wr_status) status_d = status_q & ~wdata;
        // Set wins over a same-edge clear.
        status_d = status_d | rise;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            armed_q  <= '0;
            fill_q   <= '0;
            out_q    <= '0;
            status_q <= '0;
            enable_q <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            fill_q   <= fill_d;
            out_q    <= out_d;
            status_q <= status_d;
            enable_q <= enable_d;
        end
    end

    assign out_o    = out_q;
    assign in_o     = sync_q;
    assign status_o = status_q;
    assign enable_o = enable_q;
    assign pend_o   = |(status_q & enable_q);

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS 8-bit IO channels with edge-triggered
// interrupt status, per-port irq/nmi routing and registered read data.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hBFF0,
    parameter int          NUM_PORTS = 2,
    parameter bit          LEGACY    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready,
    input  logic [15:0]            address_next,
    input  logic                   write_next,
    input  logic [7:0]             data_i,
    input  logic [8*NUM_PORTS-1:0] pins_in,
    output logic [8*NUM_PORTS-1:0] pins_out,
    output logic [7:0]             data_o,
    output logic                   hit,
    output logic                   irq,
    output logic                   nmi
);

    logic                           in_window;
    logic [3:0]                     offset;
    logic                           wr_en;
    logic [NUM_PORTS-1:0][7:0]      chan_out;
    logic [NUM_PORTS-1:0][7:0]      chan_in;
    logic [NUM_PORTS-1:0][7:0]      chan_status;
    logic [NUM_PORTS-1:0][7:0]      chan_enable;
    logic [NUM_PORTS-1:0]           chan_pend;
    logic [NUM_PORTS-1:0]           wr_out, wr_status, wr_enable;
    logic [7:0]                     rdata;

    logic [NUM_PORTS-1:0] nmisel_q, nmisel_d;
    logic [7:0]           data_o_q, data_o_d;
    logic                 hit_q,    hit_d;
    logic                 irq_q,    irq_d;
    logic                 nmi_q,    nmi_d;

    assign in_window = (address_next[15:4] == BASE_ADDR[15:4]);
    assign offset    = address_next[3:0];
    assign wr_en     = ready & in_window & write_next;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
        assign wr_out[p]    = wr_en && (offset == reg_offset(p, OFF_OUT));
        assign wr_status[p] = wr_en && (offset == reg_offset(p, OFF_STATUS));
        assign wr_enable[p] = wr_en && (offset == reg_offset(p, OFF_ENABLE));

        io_port_chan u_chan (
            .clk       (clk),
            .reset     (reset),
            .pins_in   (pins_in[8*p +: 8]),
            .wr_out    (wr_out[p]),
            .wr_status (wr_status[p]),
            .wr_enable (wr_enable[p]),
            .wdata     (data_i),
            .out_o     (chan_out[p]),
            .in_o      (chan_in[p]),
            .status_o  (chan_status[p]),
            .enable_o  (chan_enable[p]),
            .pend_o    (chan_pend[p])
        );
    end

    // Read mux works on pre-edge register values, so a same-edge write
    // returns the old contents.
    always_comb begin
        rdata = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (offset == reg_offset(p, OFF_OUT))    rdata = chan_out[p];
            if (offset == reg_offset(p, OFF_IN))     rdata = chan_in[p];
            if (offset == reg_offset(p, OFF_STATUS)) rdata = chan_status[p];
            if (offset == reg_offset(p, OFF_ENABLE)) rdata = chan_enable[p];
        end
        if (offset == nmisel_offset(NUM_PORTS)) rdata[NUM_PORTS-1:0] = nmisel_q;
    end

    always_comb begin
        nmisel_d = nmisel_q;
        data_o_d = data_o_q;
        hit_d    = hit_q;
        if (wr_en && (offset == nmisel_offset(NUM_PORTS)))
            nmisel_d = data_i[NUM_PORTS-1:0];
        if (ready) begin
            hit_d    = in_window;
            data_o_d = in_window ? rdata : 8'h00;
        end
    end

    always_comb begin
        irq_d = LEGACY & chan_out[0][0];
        nmi_d = LEGACY & chan_out[0][1];
        for (int p = 0; p < NUM_PORTS; p++) begin
            irq_d = irq_d | (~nmisel_q[p] & chan_pend[p]);
            nmi_d = nmi_d | ( nmisel_q[p] & chan_pend[p]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmisel_q <= '0;
            data_o_q <= '0;
            hit_q    <= 1'b0;
            irq_q    <= 1'b0;
            nmi_q    <= 1'b0;
        end else begin
            nmisel_q <= nmisel_d;
            data_o_q <= data_o_d;
            hit_q    <= hit_d;
            irq_q    <= irq_d;
            nmi_q    <= nmi_d;
        end
    end

    assign pins_out = chan_out;
    assign data_o   = data_o_q;
    assign hit      = hit_q;
    assign irq      = irq_q;
    assign nmi      = nmi_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (BASE 16'hBFF0, 2 ports, LEGACY=1).
module tb_io_port_bank;

    localparam logic [15:0] BASE = 16'hBFF0;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [15:0] address_next;
    logic        write_next;
    logic [7:0]  data_i;
    logic [15:0] pins_in;
    logic [15:0] pins_out;
    logic [7:0]  data_o;
    logic        hit, irq, nmi;

    int n_checks = 0;
    int n_fail   = 0;

    io_port_bank #(.BASE_ADDR(BASE), .NUM_PORTS(2), .LEGACY(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .address_next (address_next),
        .write_next   (write_next),
        .data_i       (data_i),
        .pins_in      (pins_in),
        .pins_out     (pins_out),
        .data_o       (data_o),
        .hit          (hit),
        .irq          (irq),
        .nmi          (nmi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic rdy, input logic [15:0] addr, input logic we, input logic [7:0] d);
        ready        = rdy;
        address_next = addr;
        write_next   = we;
        data_i       = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b1, 16'h0000, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b0; address_next = '0; write_next = 1'b0; data_i = '0; pins_in = '0;
        #2;
        check("rst_pins_out", pins_out, 0);
        check("rst_data_o",   data_o,   0);
        check("rst_hit",      hit,      0);
        check("rst_irq",      irq,      0);
        check("rst_nmi",      nmi,      0);
        tick();
        reset = 1'b0;
        idle(4);

        // Basic OUT write/read, read-during-write, unused and out-of-window reads
        bus(1'b1, BASE + 0, 1'b1, 8'hA5);
        check("wr_pins_out", pins_out, 16'h00A5);
        check("wr_hit",      hit,      1);
        check("wr_old_data", data_o,   8'h00);
        bus(1'b1, BASE + 0, 1'b0, 8'h00);
        check("rd_out0",     data_o,   8'hA5);
        check("rd_hit",      hit,      1);
        check("legacy_irq",  irq,      1);
        check("legacy_nmi0", nmi,      0);
        bus(1'b1, BASE + 0, 1'b1, 8'h5A);
        check("rdw_old",     data_o,   8'hA5);
        check("rdw_pins",    pins_out, 16'h005A);
        bus(1'b1, BASE + 5, 1'b0, 8'h00);
        check("rd_in1",      data_o,   8'h00);
        check("rd_in1_hit",  hit,      1);
        check("legacy_nmi1", nmi,      1);
        check("legacy_irq0", irq,      0);
        bus(1'b1, BASE + 0, 1'b1, 8'h00);
        bus(1'b1, 16'h1234, 1'b0, 8'h00);
        check("outside_data", data_o, 8'h00);
        check("outside_hit",  hit,    0);
        check("quiet_irq",    irq,    0);
        check("quiet_nmi",    nmi,    0);
        bus(1'b1, BASE + 9, 1'b0, 8'h00);
        check("unused_data", data_o, 8'h00);
        check("unused_hit",  hit,    1);

        // Port 1 bit0 interrupt to irq, then W1C
        bus(1'b1, BASE + 7, 1'b1, 8'h01);
        bus(1'b1, BASE + 7, 1'b0, 8'h00);
        check("rd_enable1", data_o, 8'h01);
        pins_in[8] = 1'b1;
        bus(1'b1, BASE + 6, 1'b0, 8'h00);             // E0
        bus(1'b1, BASE + 6, 1'b0, 8'h00);             // E1
        check("e1_irq", irq, 0);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);             // E2
        check("e2_status1", data_o, 8'h00);
        check("e2_irq",     irq,    0);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);             // E3
        check("e3_status1", data_o, 8'h01);
        check("e3_irq",     irq,    1);
        check("e3_nmi",     nmi,    0);
        bus(1'b1, BASE + 6, 1'b1, 8'h01);             // W1C
        check("w1c_irq_hold", irq, 1);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        check("w1c_irq_drop", irq, 0);
        check("w1c_status1",  data_o, 8'h00);

        // Same sequence routed to nmi
        bus(1'b1, BASE + 8, 1'b1, 8'h02);
        bus(1'b1, BASE + 8, 1'b0, 8'h00);
        check("rd_nmisel", data_o, 8'h02);
        pins_in[8] = 1'b0;
        idle(4);
        pins_in[8] = 1'b1;
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        check("n_e2_nmi", nmi, 0);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        check("n_e3_status1", data_o, 8'h01);
        check("n_e3_nmi",     nmi,    1);
        check("n_e3_irq",     irq,    0);
        bus(1'b1, BASE + 6, 1'b1, 8'h01);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        check("n_w1c_nmi", nmi, 0);

        // Rise on port 0 bit0 coinciding with a W1C of that bit
        bus(1'b1, BASE + 3, 1'b1, 8'h01);
        pins_in[0] = 1'b1;
        bus(1'b1, BASE + 2, 1'b0, 8'h00);             // E0
        bus(1'b1, BASE + 2, 1'b0, 8'h00);             // E1
        bus(1'b1, BASE + 2, 1'b1, 8'h01);             // E2: set and clear together
        bus(1'b1, BASE + 2, 1'b0, 8'h00);             // E3
        check("race_status0", data_o, 8'h01);
        check("race_irq",     irq,    1);
        bus(1'b1, BASE + 2, 1'b0, 8'h00);
        check("race_irq_hold", irq, 1);
        bus(1'b1, BASE + 2, 1'b1, 8'h01);
        bus(1'b1, BASE + 2, 1'b0, 8'h00);
        check("race_irq_drop", irq, 0);

        // ready=0 blocks writes and freezes data_o/hit
        bus(1'b1, BASE + 3, 1'b0, 8'h00);
        check("pre_nr_data", data_o, 8'h01);
        bus(1'b0, BASE + 0, 1'b1, 8'h77);
        check("nr_pins_out", pins_out, 16'h0000);
        check("nr_data_hold", data_o, 8'h01);
        check("nr_hit_hold",  hit,    1);
        bus(1'b0, 16'h0000, 1'b0, 8'h00);
        check("nr_hit_hold2", hit, 1);
        bus(1'b1, BASE + 0, 1'b0, 8'h00);
        check("nr_out0_rd", data_o, 8'h00);

        // Legacy OUT0 drive, then asynchronous reset mid-sequence
        bus(1'b1, BASE + 0, 1'b1, 8'h03);
        check("lg_pins_out", pins_out, 16'h0003);
        bus(1'b1, BASE + 0, 1'b0, 8'h00);
        check("lg_irq", irq, 1);
        check("lg_nmi", nmi, 1);
        #2;
        reset = 1'b1;
        pins_in[1] = 1'b1;
        #1;
        check("ar_pins_out", pins_out, 0);
        check("ar_data_o",   data_o,   0);
        check("ar_hit",      hit,      0);
        check("ar_irq",      irq,      0);
        check("ar_nmi",      nmi,      0);
        tick();
        reset = 1'b0;

        // Inputs high across reset release must not raise STATUS
        idle(4);
        bus(1'b1, BASE + 3, 1'b1, 8'h03);
        bus(1'b1, BASE + 7, 1'b1, 8'h01);
        idle(4);
        check("nofalse_irq", irq, 0);
        bus(1'b1, BASE + 2, 1'b0, 8'h00);
        check("nofalse_status0", data_o, 8'h00);
        bus(1'b1, BASE + 6, 1'b0, 8'h00);
        check("nofalse_status1", data_o, 8'h00);
        pins_in[0] = 1'b0;
        idle(4);
        pins_in[0] = 1'b1;
        idle(4);
        bus(1'b1, BASE + 2, 1'b0, 8'h00);
        check("rerise_status0", data_o, 8'h01);
        check("rerise_irq",     irq,    1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
